// File: rtl/light_phase_sequencer.sv
// Two-approach traffic light phase sequencer with 1 s prescaler,
// per-phase countdown and a night-mode flashing-yellow override.
module light_phase_sequencer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       night,
  input  logic [6:0] r_end,
  input  logic [6:0] y_end,
  input  logic [6:0] g_end,
  output logic [2:0] sel,
  output logic [2:0] light_A,
  output logic [2:0] light_B,
  output logic       sec_tick,
  output logic       phase_start
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] A_GO   = 3'd1;
  localparam logic [2:0] A_WARN = 3'd2;
  localparam logic [2:0] CLEAR1 = 3'd3;
  localparam logic [2:0] B_GO   = 3'd4;
  localparam logic [2:0] B_WARN = 3'd5;
  localparam logic [2:0] CLEAR2 = 3'd6;
  localparam logic [2:0] FLASH  = 3'd7;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [6:0]    remaining, rem_nxt;
  logic [2:0]    sel_nxt, adv;
  logic [2:0]    la_nxt, lb_nxt;
  logic          start_nxt;
  logic          flash_y, flash_nxt;
  logic [6:0]    dur_adv;

  function automatic logic [6:0] ld(input logic [6:0] d);
    return (d == 7'd0) ? 7'd1 : d;
  endfunction

  assign sec_tick = en && (pcnt == P_LAST);

  always_comb begin
    adv     = INIT;
    dur_adv = r_end;
    unique case (sel)
      INIT:    begin adv = A_GO;   dur_adv = g_end; end
      A_GO:    begin adv = A_WARN; dur_adv = y_end; end
      A_WARN:  begin adv = CLEAR1; dur_adv = r_end; end
      CLEAR1:  begin adv = B_GO;   dur_adv = g_end; end
      B_GO:    begin adv = B_WARN; dur_adv = y_end; end
      B_WARN:  begin adv = CLEAR2; dur_adv = r_end; end
      CLEAR2:  begin adv = A_GO;   dur_adv = g_end; end
      default: begin adv = INIT;   dur_adv = r_end; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= INIT;
      remaining   <= ld(r_end);
      pcnt        <= '0;
      phase_start <= 1'b0;
      flash_y     <= 1'b0;
      light_A     <= LR;
      light_B     <= LR;
    end else begin
      sel         <= sel_nxt;
      remaining   <= rem_nxt;
      pcnt        <= pcnt_nxt;
      phase_start <= start_nxt;
      flash_y     <= flash_nxt;
      light_A     <= la_nxt;
      light_B     <= lb_nxt;
    end
  end

  // night overrides any countdown, including the advancing tick
  always_comb begin
    sel_nxt   = sel;
    rem_nxt   = remaining;
    pcnt_nxt  = pcnt;
    start_nxt = 1'b0;
    flash_nxt = flash_y;
    if (sel == FLASH) begin
      if (!night) begin
        sel_nxt   = INIT;
        rem_nxt   = ld(r_end);
        pcnt_nxt  = '0;
        start_nxt = 1'b1;
      end else if (en) begin
        pcnt_nxt = sec_tick ? '0 : pcnt + 1'b1;
        if (sec_tick)
          flash_nxt = ~flash_y;
      end
    end else if (night) begin
      sel_nxt   = FLASH;
      pcnt_nxt  = '0;
      start_nxt = 1'b1;
      flash_nxt = 1'b1;
    end else if (en) begin
      pcnt_nxt = sec_tick ? '0 : pcnt + 1'b1;
      if (sec_tick) begin
        if (remaining > 7'd1) begin
          rem_nxt = remaining - 7'd1;
        end else begin
          sel_nxt   = adv;
          rem_nxt   = ld(dur_adv);
          start_nxt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    la_nxt = LR;
    lb_nxt = LR;
    unique case (1'b1)
      (sel_nxt == A_GO):   la_nxt = LG;
      (sel_nxt == A_WARN): la_nxt = LY;
      (sel_nxt == B_GO):   lb_nxt = LG;
      (sel_nxt == B_WARN): lb_nxt = LY;
      (sel_nxt == FLASH): begin
        la_nxt = flash_nxt ? LY : 3'b000;
        lb_nxt = flash_nxt ? LY : 3'b000;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Scoreboard bench for light_phase_sequencer: expected phases are
// queued by the stimulus and closed out by a negedge monitor.
module tb_light_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       night = 1'b0;
  logic [6:0] r_end = 7'd2;
  logic [6:0] y_end = 7'd1;
  logic [6:0] g_end = 7'd3;
  logic [2:0] sel, light_A, light_B;
  logic       sec_tick, phase_start;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] sel;
    int         len;
    logic       ps;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  light_phase_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .night(night),
    .r_end(r_end),
    .y_end(y_end),
    .g_end(g_end),
    .sel(sel),
    .light_A(light_A),
    .light_B(light_B),
    .sec_tick(sec_tick),
    .phase_start(phase_start)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // {A,B} lamps at the first cycle of each phase
  function automatic logic [5:0] lamps(input logic [2:0] s);
    case (s)
      3'd1:    return 6'b001_100;
      3'd2:    return 6'b010_100;
      3'd4:    return 6'b100_001;
      3'd5:    return 6'b100_010;
      3'd7:    return 6'b010_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic push(input logic [2:0] s, input int len, input logic ps);
    exp_t e;
    e.sel = s;
    e.len = len;
    e.ps  = ps;
    q.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      check("timeout_queue", q.size(), 0);
      q.delete();
    end
  endtask

  logic       active = 1'b0;
  int         cur_len = 0;
  logic [2:0] st_sel, st_la, st_lb;
  logic       st_ps;
  logic [2:0] yexp;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
    end else begin
      if (active && sel == st_sel) begin
        cur_len++;
      end else begin
        if (active) begin
          if (q.size() == 0) begin
            check("sb_empty", q.size(), 1);
          end else begin
            e = q.pop_front();
            check("phase_sel", st_sel, e.sel);
            check("phase_len", cur_len, e.len);
            check("phase_lamp_a", st_la, lamps(e.sel) >> 3);
            check("phase_lamp_b", st_lb, lamps(e.sel) & 6'h7);
            check("phase_start", st_ps, e.ps);
          end
        end
        st_sel  = sel;
        st_la   = light_A;
        st_lb   = light_B;
        st_ps   = phase_start;
        cur_len = 1;
        active  = 1'b1;
      end
      if (sel == 3'd7) begin
        yexp = (((cur_len - 1) / 4) % 2 == 0) ? 3'b010 : 3'b000;
        check("flash_a", light_A, yexp);
        check("flash_b", light_B, yexp);
        check("flash_tick", sec_tick, (cur_len % 4) == 0);
      end else begin
        check("lamp_invariant",
              (light_A[1] | light_A[0]) & (light_B[1] | light_B[0]), 0);
      end
      if (!en)
        check("freeze_tick", sec_tick, 0);
    end
  end

  initial begin
    // reset, INIT and a full cycle with g=3 y=1 r=2
    push(0, 8, 0);
    push(1, 12, 1);
    push(2, 4, 1);
    push(3, 8, 1);
    push(4, 12, 1);
    push(5, 4, 1);
    push(6, 8, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_empty(200);

    // zero yellow and a mid-phase green change
    push(1, 12, 1);
    push(2, 4, 1);
    push(3, 8, 1);
    push(4, 36, 1);
    push(5, 4, 1);
    push(6, 8, 1);
    repeat (3) @(posedge clk);
    #1;
    g_end = 7'd9;
    y_end = 7'd0;
    wait_empty(300);

    // enable freeze inside a 36-cycle A_GO
    push(1, 46, 1);
    push(2, 4, 1);
    push(3, 8, 1);
    push(4, 12, 1);
    repeat (5) @(posedge clk);
    #1;
    en    = 1'b0;
    g_end = 7'd3;
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    wait_empty(300);

    // night on the advancing edge of B_WARN, release on a toggle edge
    push(5, 4, 1);
    push(7, 12, 1);
    push(0, 8, 1);
    push(1, 12, 1);
    push(2, 4, 1);
    push(3, 8, 1);
    push(4, 12, 1);
    push(5, 4, 1);
    repeat (3) @(posedge clk);
    #1 night = 1'b1;
    repeat (12) @(posedge clk);
    #1 night = 1'b0;
    wait_empty(300);

    // reset during CLEAR2
    push(0, 8, 0);
    push(1, 12, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_empty(200);

    // reset during FLASH, with night still high on the reset edge
    push(2, 2, 1);
    push(0, 8, 0);
    push(1, 12, 1);
    @(posedge clk);
    #1 night = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    night = 1'b0;
    wait_empty(200);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_phase_sequencer.md
# light_phase_sequencer

Phase sequencer for the two-approach traffic light (approach A, approach B). It generates the 3-bit phase select `sel` and the A/B lamp drives from a 1-second tick derived from `clk`. It sits directly upstream of the countdown block, which consumes `sel` together with the same `r_end`/`y_end`/`g_end` duration inputs. It also provides a night-mode flashing-yellow override.

## Interface
- `TICK_DIV`, default 50_000_000: number of `clk` cycles per 1-second tick. Must be ≥2.
- `clk`  input  1  system clock; all state changes on its rising edge
- `rst`  input  1  synchronous reset, active-high
- `en`  input  1  run enable; low freezes all timing state
- `night`  input  1  night mode request (flashing yellow on both approaches)
- `r_end`  input  7  all-red clearance duration, seconds
- `y_end`  input  7  yellow duration, seconds
- `g_end`  input  7  green duration, seconds
- `sel`  output  3  current phase code (0–7), registered
- `light_A`  output  3  lamps {R,Y,G} for approach A, registered
- `light_B`  output  3  lamps {R,Y,G} for approach B, registered
- `sec_tick`  output  1  one-cycle pulse at each 1-second boundary
- `phase_start`  output  1  one-cycle pulse in the first cycle of each new phase

## Operation
- Phases, written as sel: name, A lamps / B lamps, duration:
  - 0: INIT, R/R, r_end
  - 1: A_GO, G/R, g_end
  - 2: A_WARN, Y/R, y_end
  - 3: CLEAR1, R/R, r_end
  - 4: B_GO, R/G, g_end
  - 5: B_WARN, R/Y, y_end
  - 6: CLEAR2, R/R, r_end
  - 7: FLASH, both Y toggling, indefinite
- Transitions:
  - Normal order is 0→1→2→3→4→5→6→1, and the cycle repeats from 1.
  - INIT is entered only from reset or on leaving FLASH.
- Timer:
  - 7-bit `remaining` register plus a prescaler `pcnt` counting 0..TICK_DIV-1.
  - On phase entry, `remaining` loads the duration for the new phase from the inputs at that edge. A duration of 0 is loaded as 1. Durations are not re-sampled mid-phase.
  - `sec_tick` = en && (pcnt == TICK_DIV-1); it is combinational from `pcnt`.
  - On `sec_tick` with remaining > 1, `remaining` decrements.
  - On `sec_tick` with remaining == 1, the phase advances and `pcnt` clears to 0.
- Night mode:
  - When `night`=1 in any phase 0–6, the next edge enters FLASH regardless of `remaining`, with `pcnt` cleared.
  - In FLASH, both approaches' Y lamps toggle on every `sec_tick`. Y is on in the first second. R and G are off.
  - When `night`=0 in FLASH, the next edge enters INIT with r_end loaded.
- `en`=0 holds `pcnt`, `remaining`, `sel` and the lamps; `sec_tick` stays 0. `night` is still honoured while `en`=0.
- Invariant: A and B are never both showing G or Y except in FLASH. Verification asserts this every cycle.

## Timing
- Reset values (in the cycle after a `rst`-high edge):
  - sel=0, light_A=light_B=3'b100, pcnt=0, phase_start=0.
  - remaining = r_end sampled at that edge, 0 mapped to 1.
- Reset mid-phase or mid-FLASH behaves identically. `rst` has priority over `night` and `en`.
- Phase length: exactly dur×TICK_DIV enabled cycles, counted from the first cycle the new `sel` is visible.
- Output timing:
  - `sel` and the lamps change on the same edge. No cycle shows a mixed combination.
  - `phase_start` is high in that first cycle. The INIT phase following reset does not raise `phase_start`.
- Simultaneous events:
  - `night` rising on the advancing edge: FLASH wins; the sequence does not advance to the next phase.
  - `night` falling on a FLASH toggle edge: INIT wins; lamps go R/R.
- `remaining` never underflows and never exceeds 127. Duration inputs are unsigned; no sums are formed.

## Test plan
- **Reset and INIT:** TICK_DIV=4, r_end=2, rst for 2 cycles, then release. Required: sel=0 and R/R for exactly 8 cycles, then sel=1, light_A=001, light_B=100, phase_start=1 for one cycle.
- **Full cycle:** TICK_DIV=4, g=3, y=1, r=2. Required: phase lengths of 12, 4, 8, 12, 4, 8 cycles for sel 1 through 6, then sel returns to 1. The lamp invariant holds throughout.
- **Zero duration and mid-phase change:** y_end=0. Required: the yellow phase lasts 4 cycles. Changing g_end from 3 to 9 during A_GO does not alter the current phase's 12 cycles; the next B_GO lasts 36 cycles.
- **Enable freeze:** deassert `en` for 10 cycles mid-A_GO. Required: `sel`, lamps, `pcnt` and `remaining` unchanged; the phase ends 10 cycles later than it otherwise would.
- **Night mode:**
  - Assert `night` during B_WARN. Required: next cycle sel=7, light_A=light_B=010, toggling every 4 cycles.
  - Deassert `night`. Required: next cycle sel=0, R/R, `phase_start`=1.
- **Reset mid-operation:** pulse `rst` during CLEAR2 and, separately, during FLASH. Required: reset values exactly as listed under Timing, followed by a full r_end INIT.
